// File: rtl/led_blinker.sv
// led_blinker: multi-channel LED driver. Each channel has a free-running counter
// and a mode (OFF, ON, BLINK, BREATHE). Channels are configured one at a time
// through a valid/ready write port.
//
// Optional feature macro: LED_BLINKER_BREATHE_EN. When it is defined, mode 11 is a
// triangle-ramp PWM "breathe". When it is undefined, mode 11 behaves as BLINK and
// no PWM comparator is built.
//
// Parameters:
//   NCH    - number of LED channels (1..16)
//   CWIDTH - per-channel counter width (must be >= 2*PWIDTH+1)
//   PWIDTH - breathe PWM resolution in bits
//
// Ports:
//   clk_i       - clock, rising edge
//   rst_ni      - asynchronous active-low reset
//   cfg_valid_i - config write request
//   cfg_ready_o - write can be accepted (low for the commit cycle after an accept)
//   cfg_ch_i    - target channel index
//   cfg_mode_i  - 00 OFF, 01 ON, 10 BLINK, 11 BREATHE
//   cfg_shift_i - blink tap bit index (clamped to CWIDTH-1)
//   cfg_err_o   - one-cycle pulse when a write names a channel that does not exist
//   led_o       - registered LED drive, bit n = channel n
module led_blinker #(
   parameter int unsigned NCH    = 4,
   parameter int unsigned CWIDTH = 26,
   parameter int unsigned PWIDTH = 8
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   input  logic           cfg_valid_i,
   output logic           cfg_ready_o,
   input  logic [3:0]     cfg_ch_i,
   input  logic [1:0]     cfg_mode_i,
   input  logic [4:0]     cfg_shift_i,
   output logic           cfg_err_o,
   output logic [NCH-1:0] led_o
);

   typedef enum logic [1:0] {
      ModeOff     = 2'b00,
      ModeOn      = 2'b01,
      ModeBlink   = 2'b10,
      ModeBreathe = 2'b11
   } mode_e;

   // Largest tap index that fits both the counter and the 5-bit shift field.
   localparam int unsigned MaxShift = (CWIDTH - 1 > 31) ? 31 : CWIDTH - 1;

   if (NCH < 1 || NCH > 16) begin : g_bad_nch
      $error("led_blinker: NCH must be in 1..16");
   end
   if (CWIDTH < 2 * PWIDTH + 1) begin : g_bad_cwidth
      $error("led_blinker: CWIDTH must be >= 2*PWIDTH+1");
   end

   mode_e             r_mode  [NCH];
   logic [4:0]        r_shift [NCH];
   logic [CWIDTH-1:0] r_cnt   [NCH];
   logic              r_ready;
   logic              r_err;
   logic [NCH-1:0]    r_led;

   logic              w_accept;
   logic              w_ch_ok;
   logic [4:0]        w_shift_clamped;
   logic [NCH-1:0]    w_blink;
   logic [NCH-1:0]    w_led_d;

   assign w_accept        = cfg_valid_i & r_ready;
   assign w_ch_ok         = 32'(cfg_ch_i) < NCH;
   assign w_shift_clamped = (32'(cfg_shift_i) > MaxShift) ? 5'(MaxShift) : cfg_shift_i;

   for (genvar n = 0; n < NCH; n++) begin : g_blink
      assign w_blink[n] = r_cnt[n][r_shift[n]];
   end

`ifdef LED_BLINKER_BREATHE_EN
   logic [NCH-1:0] w_breathe;

   for (genvar n = 0; n < NCH; n++) begin : g_breathe
      logic [PWIDTH-1:0] w_lvl;
      // Upper counter bits ramp the level up while the MSB is 0 and down while it
      // is 1; the low bits act as the PWM sawtooth the level is compared with.
      assign w_lvl = r_cnt[n][CWIDTH-1] ? ~r_cnt[n][CWIDTH-2 -: PWIDTH]
                                        :  r_cnt[n][CWIDTH-2 -: PWIDTH];
      assign w_breathe[n] = w_lvl > r_cnt[n][PWIDTH-1:0];
   end
`endif

   always_comb begin
      w_led_d = '0;
      for (int n = 0; n < NCH; n++) begin
         case (r_mode[n])
            ModeOff:     w_led_d[n] = 1'b0;
            ModeOn:      w_led_d[n] = 1'b1;
            ModeBlink:   w_led_d[n] = w_blink[n];
`ifdef LED_BLINKER_BREATHE_EN
            ModeBreathe: w_led_d[n] = w_breathe[n];
`else
            ModeBreathe: w_led_d[n] = w_blink[n];
`endif
            default:     w_led_d[n] = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_ready <= 1'b0;
         r_err   <= 1'b0;
         r_led   <= '0;
         for (int n = 0; n < NCH; n++) begin
            r_mode[n]  <= ModeOff;
            r_shift[n] <= '0;
            r_cnt[n]   <= '0;
         end
      end else begin
         // Ready drops for exactly the commit cycle that follows every accept.
         r_ready <= ~w_accept;
         r_err   <= w_accept & ~w_ch_ok;
         r_led   <= w_led_d;
         for (int n = 0; n < NCH; n++) begin
            if (w_accept && w_ch_ok && (cfg_ch_i == 4'(n))) begin
               r_mode[n]  <= mode_e'(cfg_mode_i);
               r_shift[n] <= w_shift_clamped;
               r_cnt[n]   <= '0;
            end else begin
               r_cnt[n]   <= r_cnt[n] + CWIDTH'(1);
            end
         end
      end
   end

   assign cfg_ready_o = r_ready;
   assign cfg_err_o   = r_err;
   assign led_o       = r_led;

endmodule

// File: tb/tb_led_blinker.sv
// Bench for led_blinker. Stimulus pushes time-stamped expectations into a
// scoreboard queue; an independent monitor pops and compares them on the falling
// edge of the cycle they belong to. A second instance (CWIDTH=17) covers the shift
// clamp and mode 11 at a counter width short enough to simulate.
module tb_led_blinker;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;

   logic       v1 = 1'b0;
   logic [3:0] ch1 = '0;
   logic [1:0] md1 = '0;
   logic [4:0] sh1 = '0;
   logic       rdy1, err1;
   logic [3:0] led1;

   logic       v2 = 1'b0;
   logic [3:0] ch2 = '0;
   logic [1:0] md2 = '0;
   logic [4:0] sh2 = '0;
   logic       rdy2, err2;
   logic [3:0] led2;

   led_blinker #(.NCH(4), .CWIDTH(26), .PWIDTH(8)) u_dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .cfg_valid_i(v1),
      .cfg_ready_o(rdy1),
      .cfg_ch_i   (ch1),
      .cfg_mode_i (md1),
      .cfg_shift_i(sh1),
      .cfg_err_o  (err1),
      .led_o      (led1)
   );

   led_blinker #(.NCH(4), .CWIDTH(17), .PWIDTH(8)) u_dut17 (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .cfg_valid_i(v2),
      .cfg_ready_o(rdy2),
      .cfg_ch_i   (ch2),
      .cfg_mode_i (md2),
      .cfg_shift_i(sh2),
      .cfg_err_o  (err2),
      .led_o      (led2)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      int         sig;
      logic [3:0] mask;
      logic [3:0] val;
      int         tid;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Keep the queue sorted by cycle so the monitor only ever looks at the head.
   function automatic void expect_at(input int c, input int sig, input logic [3:0] m,
                                     input logic [3:0] v, input int tid);
      exp_t e;
      int   i;
      e.cyc = c; e.sig = sig; e.mask = m; e.val = v; e.tid = tid;
      i = sb.size();
      while (i > 0 && sb[i-1].cyc > c) i--;
      sb.insert(i, e);
   endfunction

   function automatic string sig_name(input int s);
      case (s)
         0:       return "led_o";
         1:       return "cfg_ready_o";
         2:       return "cfg_err_o";
         3:       return "led_o(cw17)";
         default: return "cfg_ready_o(cw17)";
      endcase
   endfunction

   function automatic logic [3:0] sample(input int s);
      case (s)
         0:       return led1;
         1:       return {3'b000, rdy1};
         2:       return {3'b000, err1};
         3:       return led2;
         default: return {3'b000, rdy2};
      endcase
   endfunction

   function automatic logic bitk(input int k, input int b);
      return ((k >> b) & 1) != 0;
   endfunction

   // Monitor
   initial begin
      exp_t       e;
      logic [3:0] act;
      forever begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e   = sb.pop_front();
            act = sample(e.sig);
            checks = checks + 1;
            if (e.cyc != cyc || (act & e.mask) !== (e.val & e.mask)) begin
               errors = errors + 1;
               $display("FAIL %s test%0d cycle %0d: got %b required %b (mask %b)",
                        sig_name(e.sig), e.tid, e.cyc, act & e.mask, e.val & e.mask, e.mask);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Stimulus
   initial begin
      int b2, a0, a, c1, c0, lim;
      int wstart[4];
      int wlvl[4];
      wstart[0] = 0;     wlvl[0] = 0;
      wstart[1] = 256;   wlvl[1] = 1;
      wstart[2] = 32768; wlvl[2] = 128;
      wstart[3] = 65536; wlvl[3] = 255;

      // Test 1: reset held 5 cycles with a pending write
      rst_n = 1'b0; v1 = 1'b1; ch1 = 4'd0; md1 = 2'b01; sh1 = 5'd0;
      repeat (5) begin
         tick();
         expect_at(cyc, 0, 4'hF, 4'h0, 1);
         expect_at(cyc, 1, 4'h1, 4'h0, 1);
         expect_at(cyc, 2, 4'h1, 4'h0, 1);
      end
      rst_n = 1'b1; v1 = 1'b0;
      expect_at(cyc + 1, 1, 4'h1, 4'h1, 1);
      expect_at(cyc + 1, 0, 4'hF, 4'h0, 1);
      tick();

      // Test 2: ch2 BLINK shift 3 -> 8 low, 8 high; other bits stay 0
      v1 = 1'b1; ch1 = 4'd2; md1 = 2'b10; sh1 = 5'd3; b2 = cyc + 1;
      tick();
      v1 = 1'b0;
      expect_at(b2,     1, 4'h1, 4'h0, 2);
      expect_at(b2 + 1, 1, 4'h1, 4'h1, 2);
      for (int k = 0; k < 32; k++) begin
         expect_at(b2 + 1 + k, 0, 4'b0100, {1'b0, bitk(k, 3), 2'b00}, 2);
         expect_at(b2 + 1 + k, 0, 4'b1011, 4'h0, 2);
      end
      repeat (32) tick();

      // Test 3: valid held 4 cycles (ch0 BLINK shift 1, then ch1 ON)
      v1 = 1'b1; ch1 = 4'd0; md1 = 2'b10; sh1 = 5'd1; a0 = cyc + 1;
      expect_at(cyc, 1, 4'h1, 4'h1, 3);
      for (int k = 0; k < 8; k++)
         expect_at(a0 + 1 + k, 0, 4'b0001, {3'b000, bitk(k, 1)}, 3);
      expect_at(a0 + 2, 0, 4'b0010, 4'b0000, 3);
      for (int k = 3; k < 7; k++)
         expect_at(a0 + k, 0, 4'b0010, 4'b0010, 3);
      tick();
      expect_at(cyc, 1, 4'h1, 4'h0, 3);
      tick();
      expect_at(cyc, 1, 4'h1, 4'h1, 3);
      ch1 = 4'd1; md1 = 2'b01; sh1 = 5'd0;
      tick();
      expect_at(cyc, 1, 4'h1, 4'h0, 3);
      tick();
      v1 = 1'b0;
      expect_at(cyc, 1, 4'h1, 4'h1, 3);
      repeat (8) tick();

      // Test 4: write to nonexistent ch7 -> err pulse, LEDs carry on untouched
      v1 = 1'b1; ch1 = 4'd7; md1 = 2'b01; sh1 = 5'd0; a = cyc + 1;
      for (int t = a - 1; t <= a + 3; t++) begin
         expect_at(t, 2, 4'h1, {3'b000, t == a}, 4);
         expect_at(t, 0, 4'hF, {1'b0, bitk(t - b2 - 1, 3), 1'b1, bitk(t - a0 - 1, 1)}, 4);
      end
      expect_at(a, 1, 4'h1, 4'h0, 4);
      tick();
      v1 = 1'b0;
      repeat (4) tick();

      // Test 5: reset during the commit cycle leaves nothing behind
      v1 = 1'b1; ch1 = 4'd3; md1 = 2'b01; sh1 = 5'd0;
      tick();
      rst_n = 1'b0; v1 = 1'b0;
      expect_at(cyc, 0, 4'hF, 4'h0, 5);
      expect_at(cyc, 1, 4'h1, 4'h0, 5);
      tick();
      rst_n = 1'b1;
      expect_at(cyc + 1, 1, 4'h1, 4'h1, 5);
      for (int k = 1; k <= 4; k++)
         expect_at(cyc + k, 0, 4'hF, 4'h0, 5);
      repeat (5) tick();

      // Test 6: CWIDTH=17 instance; ch1 shift 31 clamps to tap 16
      v2 = 1'b1; ch2 = 4'd1; md2 = 2'b10; sh2 = 5'd31; c1 = cyc + 1;
      tick();
      v2 = 1'b0;
      expect_at(c1, 4, 4'h1, 4'h0, 6);
      expect_at(c1 + 1 + 0,     3, 4'b0010, 4'b0000, 6);
      expect_at(c1 + 1 + 32767, 3, 4'b0010, 4'b0000, 6);
      expect_at(c1 + 1 + 32768, 3, 4'b0010, 4'b0000, 6);
      expect_at(c1 + 1 + 65535, 3, 4'b0010, 4'b0000, 6);
      expect_at(c1 + 1 + 65536, 3, 4'b0010, 4'b0010, 6);
      expect_at(c1 + 1 + 65537, 3, 4'b0010, 4'b0010, 6);
      tick();

      // Test 7: ch0 mode 11 on the CWIDTH=17 instance
      v2 = 1'b1; ch2 = 4'd0; md2 = 2'b11; sh2 = 5'd2; c0 = cyc + 1;
      tick();
      v2 = 1'b0;
`ifdef LED_BLINKER_BREATHE_EN
      // Level is 0, 1, 128 and 255 in these 256-cycle windows.
      for (int w = 0; w < 4; w++)
         for (int j = 0; j < 256; j++)
            expect_at(c0 + 1 + wstart[w] + j, 3, 4'b0001, {3'b000, wlvl[w] > j}, 7);
`else
      // Without the breathe build, mode 11 is plain BLINK on tap 2.
      for (int k = 0; k < 16; k++)
         expect_at(c0 + 1 + k, 3, 4'b0001, {3'b000, bitk(k, 2)}, 7);
`endif

      lim = cyc + 70000;
      while (sb.size() > 0 && cyc < lim) tick();
      if (sb.size() != 0) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("FAIL drain: %0d expectations still pending, required 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
